// File: rtl/traffic_light_ctrl.sv
// Multi-direction traffic-light sequencer: green -> yellow -> all-red per direction,
// with an optional all-red pedestrian WALK phase and a freeze enable.
module traffic_light_ctrl #(
    parameter int N_DIR       = 2,
    parameter int DIR_W       = 1,
    parameter int CNT_W       = 8,
    parameter int GREEN_CYC   = 4,
    parameter int YELLOW_CYC  = 2,
    parameter int ALL_RED_CYC = 1,
    parameter int WALK_CYC    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               ped_req,
    output logic [3*N_DIR-1:0] light,
    output logic               walk,
    output logic [DIR_W-1:0]   dir_idx,
    output logic [1:0]         phase
);

    localparam logic [1:0] PH_GREEN   = 2'b00;
    localparam logic [1:0] PH_YELLOW  = 2'b01;
    localparam logic [1:0] PH_ALL_RED = 2'b10;
    localparam logic [1:0] PH_WALK    = 2'b11;

    localparam logic [CNT_W-1:0] GREEN_LD   = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALL_RED_LD = CNT_W'(ALL_RED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LD    = CNT_W'(WALK_CYC - 1);
    localparam logic [DIR_W-1:0] LAST_DIR   = DIR_W'(N_DIR - 1);

    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nx;
    logic [1:0]       phase_nx;
    logic [DIR_W-1:0] dir_nx;
    logic [DIR_W-1:0] dir_next;
    logic             ped_pending;
    logic             pend_nx;
    logic             dir_bad;

    // Out-of-range direction codes only exist when N_DIR is not a power of two.
    generate
        if (N_DIR < (1 << DIR_W)) begin : g_dir_chk
            assign dir_bad = (dir_idx > LAST_DIR);
        end else begin : g_dir_full
            assign dir_bad = 1'b0;
        end
    endgenerate

    assign dir_next = (dir_idx == LAST_DIR) ? '0 : dir_idx + 1'b1;

    always_comb begin
        phase_nx = phase;
        timer_nx = timer;
        dir_nx   = dir_idx;
        pend_nx  = ped_pending | (ped_req && (phase != PH_WALK));
        if (dir_bad) begin
            phase_nx = PH_ALL_RED;
            dir_nx   = LAST_DIR;
            timer_nx = ALL_RED_LD;
        end else if (enable) begin
            if (timer != '0) begin
                timer_nx = timer - 1'b1;
            end else begin
                case (phase)
                    PH_GREEN: begin
                        phase_nx = PH_YELLOW;
                        timer_nx = YELLOW_LD;
                    end
                    PH_YELLOW: begin
                        phase_nx = PH_ALL_RED;
                        timer_nx = ALL_RED_LD;
                    end
                    PH_ALL_RED: begin
                        // A request landing on the deciding edge is served immediately.
                        if (ped_pending || ped_req) begin
                            phase_nx = PH_WALK;
                            timer_nx = WALK_LD;
                            pend_nx  = 1'b0;
                        end else begin
                            phase_nx = PH_GREEN;
                            timer_nx = GREEN_LD;
                            dir_nx   = dir_next;
                        end
                    end
                    default: begin
                        phase_nx = PH_GREEN;
                        timer_nx = GREEN_LD;
                        dir_nx   = dir_next;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase       <= PH_ALL_RED;
            dir_idx     <= LAST_DIR;
            timer       <= ALL_RED_LD;
            ped_pending <= 1'b0;
        end else begin
            phase       <= phase_nx;
            dir_idx     <= dir_nx;
            timer       <= timer_nx;
            ped_pending <= pend_nx;
        end
    end

    // Lamps are a pure Moore decode, so reset reaches them without a clock.
    always_comb begin
        for (int d = 0; d < N_DIR; d++) begin
            light[3*d +: 3] = 3'b100;
            if (!dir_bad && (DIR_W'(d) == dir_idx)) begin
                if (phase == PH_GREEN)  light[3*d +: 3] = 3'b010;
                if (phase == PH_YELLOW) light[3*d +: 3] = 3'b001;
            end
        end
    end

    assign walk = (phase == PH_WALK);

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: two instances (2 and 4 directions) against an
// elapsed-time phase model, with directed scenarios and randomized stimulus.
module tb_traffic_light_ctrl;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        ped_req;
    logic [5:0]  light0;
    logic        walk0;
    logic [0:0]  dir0;
    logic [1:0]  phase0;
    logic [11:0] light1;
    logic        walk1;
    logic [1:0]  dir1;
    logic [1:0]  phase1;

    int vectors;
    int miscompares;

    // Model state per instance: phase id, cycles spent in phase, direction, pending request.
    int m_ph[2];
    int m_el[2];
    int m_dir[2];
    int m_pend[2];
    int nd[2];

    localparam int G = 0, Y = 1, AR = 2, WK = 3;

    traffic_light_ctrl u0 (
        .clock(clock), .reset(reset), .enable(enable), .ped_req(ped_req),
        .light(light0), .walk(walk0), .dir_idx(dir0), .phase(phase0)
    );

    traffic_light_ctrl #(.N_DIR(4), .DIR_W(2)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .ped_req(ped_req),
        .light(light1), .walk(walk1), .dir_idx(dir1), .phase(phase1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int dur(input int ph);
        case (ph)
            G:       return 4;
            Y:       return 2;
            AR:      return 1;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = AR; m_el[k] = 0; m_dir[k] = nd[k] - 1; m_pend[k] = 0;
        end
    endtask

    task automatic model_step(input logic en, input logic pr);
        for (int k = 0; k < 2; k++) begin
            int pend_next;
            pend_next = (pr && m_ph[k] != WK) ? 1 : m_pend[k];
            if (en) begin
                if (m_el[k] + 1 < dur(m_ph[k])) begin
                    m_el[k]++;
                end else begin
                    m_el[k] = 0;
                    case (m_ph[k])
                        G:  m_ph[k] = Y;
                        Y:  m_ph[k] = AR;
                        AR: if (pend_next != 0) begin
                                m_ph[k] = WK; pend_next = 0;
                            end else begin
                                m_ph[k] = G; m_dir[k] = (m_dir[k] + 1) % nd[k];
                            end
                        default: begin
                            m_ph[k] = G; m_dir[k] = (m_dir[k] + 1) % nd[k];
                        end
                    endcase
                end
            end
            m_pend[k] = pend_next;
        end
    endtask

    function automatic logic [11:0] exp_light(input int k);
        logic [11:0] l;
        l = '0;
        for (int d = 0; d < nd[k]; d++) begin
            if (d == m_dir[k] && m_ph[k] == G)      l[3*d +: 3] = 3'b010;
            else if (d == m_dir[k] && m_ph[k] == Y) l[3*d +: 3] = 3'b001;
            else                                    l[3*d +: 3] = 3'b100;
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic [11:0] l, input logic w,
                             input logic [1:0] d, input logic [1:0] p, input logic pend);
        int nonred;
        nonred = 0;
        chk($sformatf("light%0d", k), 32'(l), 32'(exp_light(k)));
        chk($sformatf("phase%0d", k), 32'(p), 32'(m_ph[k]));
        chk($sformatf("walk%0d", k), 32'(w), 32'(m_ph[k] == WK));
        chk($sformatf("dir%0d", k), 32'(d), 32'(m_dir[k]));
        chk($sformatf("pend%0d", k), 32'(pend), 32'(m_pend[k]));
        for (int i = 0; i < nd[k]; i++)
            if (l[3*i +: 3] != 3'b100) nonred++;
        chk($sformatf("single_nonred%0d", k), 32'(nonred <= 1), 32'd1);
    endtask

    task automatic check_all();
        check_dut(0, {6'b0, light0}, walk0, {1'b0, dir0}, phase0, u0.ped_pending);
        check_dut(1, light1, walk1, dir1, phase1, u1.ped_pending);
    endtask

    // Check the state settled after the last edge, then apply inputs for the next edge.
    task automatic cycle(input logic en, input logic pr, input logic rs);
        @(negedge clock);
        check_all();
        enable  = en;
        ped_req = pr;
        reset   = rs;
        if (rs) model_reset();
        else    model_step(en, pr);
    endtask

    task automatic timeout(input string tag);
        miscompares++;
        $error("FAIL %s timeout waiting for DUT state", tag);
    endtask

    initial begin
        int n;
        vectors = 0; miscompares = 0;
        nd[0] = 2; nd[1] = 4;
        reset = 1'b1; enable = 1'b1; ped_req = 1'b0;
        model_reset();

        // Reset held, then release and free-run through two full 14-cycle rotations.
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        for (int i = 0; i < 32; i++) cycle(1, 0, 0);

        // One-cycle request during direction 0 green.
        n = 0;
        while (!(phase0 == 2'b00 && dir0 == 1'b0) && n < 50) begin cycle(1, 0, 0); n++; end
        if (n >= 50) timeout("wait_green0");
        cycle(1, 1, 0);
        for (int i = 0; i < 24; i++) cycle(1, 0, 0);

        // Request held across a whole WALK, then dropped.
        for (int i = 0; i < 20; i++) cycle(1, 1, 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);

        // Freeze for five cycles mid-green.
        n = 0;
        while (!(phase0 == 2'b00 && u0.timer == 8'd2) && n < 50) begin cycle(1, 0, 0); n++; end
        if (n >= 50) timeout("wait_green_t2");
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(1, 0, 0);

        // Request during a freeze is still latched.
        for (int i = 0; i < 3; i++) cycle(0, (i == 1), 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);

        // Randomized enable / request traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0), 0);

        // Asynchronous reset between edges while direction is yellow.
        n = 0;
        while (phase0 != 2'b01 && n < 50) begin cycle(1, 0, 0); n++; end
        if (n >= 50) timeout("wait_yellow");
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_light0", 32'(light0), 32'h24);
        chk("async_phase0", 32'(phase0), 32'h2);
        chk("async_walk0", 32'(walk0), 32'h0);
        chk("async_light1", 32'(light1), 32'h924);
        chk("async_dir1", 32'(dir1), 32'h3);
        cycle(1, 0, 1);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);

        @(negedge clock);
        check_all();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised multi-direction traffic-light sequencer. It cycles N_DIR approach directions through green → yellow → all-red, with a per-phase duration for each step. It can insert an all-red pedestrian WALK phase on request and can be frozen by an enable. Lights are a Moore decode of registered state, so the only flops are state, direction index, timer and the pending flag.

## Interface
- N_DIR, 2: number of approach directions, ≥2.
- DIR_W, 1: width of the direction index, ≥ clog2(N_DIR).
- CNT_W, 8: timer width; every duration must be ≤ 2^CNT_W.
- GREEN_CYC, 4: green duration in cycles, ≥1.
- YELLOW_CYC, 2: yellow duration in cycles, ≥1.
- ALL_RED_CYC, 1: all-red clearance duration in cycles, ≥1.
- WALK_CYC, 3: pedestrian phase duration in cycles, ≥1.

- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  1 = timer runs; 0 = freeze state, timer and direction.
- ped_req  in  1  pedestrian request, level or pulse, sampled each posedge.
- light  out  3*N_DIR  per-direction lamps; slice [3d+2:3d] = {red, green, yellow} (red=100, green=010, yellow=001).
- walk  out  1  pedestrian walk lamp.
- dir_idx  out  DIR_W  direction currently owning the cycle.
- phase  out  2  00 GREEN, 01 YELLOW, 10 ALL_RED, 11 WALK.

## Operation
- Registers:
  - phase: 2 bits.
  - dir_idx.
  - timer: CNT_W bits, counts down.
  - ped_pending: 1 bit.
- Reset values:
  - phase = ALL_RED.
  - dir_idx = N_DIR-1.
  - timer = ALL_RED_CYC-1.
  - ped_pending = 0.
  - light = all directions 100.
  - walk = 0.
- Output decode is purely combinational from phase and dir_idx:
  - GREEN: direction dir_idx = 010; every other direction = 100.
  - YELLOW: direction dir_idx = 001; every other direction = 100.
  - ALL_RED and WALK: every direction = 100.
  - walk = 1 only in WALK.
  - No direction is ever green or yellow while another is non-red.
- Timer:
  - On phase entry it loads the new phase duration minus 1.
  - With enable=1, timer>0: it decrements.
  - With enable=1, timer==0: the phase transitions on that edge.
- Transitions, taken only when enable=1 and timer==0:
  - GREEN → YELLOW.
  - YELLOW → ALL_RED.
  - ALL_RED → WALK if ped_pending, else GREEN with dir_idx = (dir_idx+1) mod N_DIR.
  - WALK → GREEN with dir_idx = (dir_idx+1) mod N_DIR.
- Direction wrap: N_DIR-1 → 0. dir_idx never holds a value ≥ N_DIR.
- ped_pending:
  - Set on any posedge with ped_req=1 while phase ≠ WALK.
  - Cleared on the edge entering WALK; the clear wins over a simultaneous set.
  - ped_req during WALK is ignored.
  - Multiple requests before service collapse to one WALK.
  - ped_pending is set even while enable=0.
- Illegal encoding: an unreachable dir_idx value recovers to ALL_RED, dir_idx = N_DIR-1 on the next edge.

## Timing
- Each phase is visible for exactly its parameter count of enabled cycles.
- Without requests, one direction period is GREEN_CYC+YELLOW_CYC+ALL_RED_CYC cycles. The full rotation is N_DIR times that.
- A served request adds exactly WALK_CYC cycles after the ALL_RED that follows it.
- After reset deasserts, the first ALL_RED lasts ALL_RED_CYC cycles, then direction 0 goes green.
- enable=0 stalls everything; phase and timer resume unchanged when enable returns.
- Asserting reset mid-phase forces all outputs to their reset values asynchronously, without waiting for a clock edge.
- Request latency: a request is seen at the next ALL_RED → next-phase decision; the WALK starts on that edge at the earliest.
- A request arriving in the final ALL_RED cycle (timer==0, enable=1) is served on that same edge.

## Test plan
- Reset release, defaults, no ped_req:
  - Required: light = 100_100 for 1 cycle; then dir0 green (010) for 4 cycles, yellow for 2, all-red for 1; then dir1 green.
  - Required: the pattern repeats every 14 cycles.
- ped_req pulse of 1 cycle during dir0 GREEN:
  - Required: after dir0 ALL_RED, phase = 11 and walk = 1 for 3 cycles with all lights 100.
  - Required: then dir1 green; ped_pending = 0 afterwards.
- ped_req held high through WALK: exactly one WALK phase; a second WALK only if ped_req is still high after WALK ends.
- enable low for 5 cycles mid-GREEN (timer = 2):
  - Required: outputs and timer frozen.
  - Required: after re-enable, green lasts exactly 3 more cycles.
- N_DIR=4, DIR_W=2:
  - Required: dir_idx sequence 0, 1, 2, 3, 0.
  - Required: at every cycle at most one slice is non-100.
- Reset asserted mid-YELLOW between clock edges:
  - Required: light goes to all 100 and phase = 10 without waiting for a clock.
  - Required: after release the sequence restarts as in test 1.
